uart_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares the single write port of the UART transmitter FIFO between NUM_REQ byte-stream requesters (for example CPU register writes, a debug console and a DMA channel).
- A grant is locked from the first byte of a packet to its last byte, so bytes from different requesters never interleave on the wire.
- Includes a stall timeout that releases a grant held by a requester that stops supplying data.
- Sits between the requesters and the transmitter's tx_fifo_write_i / tx_data_i / tx_fifo_full_o signals.

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter for the UART transmitter FIFO write port.
// Latency: 1 grant cycle per packet, then bytes pass combinationally (0 cycles).
// Backpressure: tx_fifo_full_i removes ready from the granted requester; stalls release by timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int TO_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arb_en_i,
  input  logic [TO_WIDTH-1:0]    timeout_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic                   tx_fifo_full_i,
  output logic                   tx_fifo_write_o,
  output logic [7:0]             tx_data_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic                   timeout_evt_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [IW-1:0]       r_gidx;
  logic [IW-1:0]       r_rr;
  logic [TO_WIDTH-1:0] r_cnt;
  logic                r_tevt;

  logic                w_found;
  logic [IW-1:0]       w_sel_idx;
  logic [IW:0]         w_k;
  logic [NUM_REQ-1:0]  w_sel_oh;
  logic                w_xfer;
  logic                w_vld_g;
  logic                w_last_g;
  logic                w_hs;
  logic                w_to_hit;
  logic [7:0]          w_data;

  // Round-robin search: first valid requester after the rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_k       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_k = {1'b0, r_rr} + (IW+1)'(i);
      if (w_k >= (IW+1)'(NUM_REQ)) begin
        w_k = w_k - (IW+1)'(NUM_REQ);
      end
      if (!w_found && req_valid_i[w_k[IW-1:0]]) begin
        w_found   = 1'b1;
        w_sel_idx = w_k[IW-1:0];
      end
    end
  end

  assign w_sel_oh = NUM_REQ'(1) << w_sel_idx;

  // Granted-requester view; only meaningful while a grant is held.
  assign w_xfer   = (r_state == ARB_XFER);
  assign w_vld_g  = w_xfer & req_valid_i[r_gidx];
  assign w_last_g = req_last_i[r_gidx];
  assign w_hs     = w_vld_g & ~tx_fifo_full_i;

  // Stall limit reached on this counting cycle; the wider add keeps a saturated counter from wrapping into a match.
  assign w_to_hit = (timeout_i != '0) &&
                    (({1'b0, r_cnt} + (TO_WIDTH+1)'(1)) == {1'b0, timeout_i});

  // Byte mux from the granted lane; all-zero grant yields 8'h00.
  always_comb begin
    w_data = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) begin
        w_data = w_data | req_data_i[8*k +: 8];
      end
    end
  end

  assign req_ready_o     = w_xfer ? (r_grant & {NUM_REQ{~tx_fifo_full_i}}) : '0;
  assign tx_fifo_write_o = w_hs;
  assign tx_data_o       = w_data;
  assign grant_o         = r_grant;
  assign busy_o          = w_xfer;
  assign timeout_evt_o   = r_tevt;

  // Arbitration FSM: grant issue, packet lock until last byte, stall timeout release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_rr    <= IW'(NUM_REQ-1);
      r_cnt   <= '0;
      r_tevt  <= 1'b0;
    end else begin
      r_tevt <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (arb_en_i && w_found) begin
            r_grant <= w_sel_oh;
            r_gidx  <= w_sel_idx;
            r_cnt   <= '0;
            r_state <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (w_hs) begin
            r_cnt <= '0;
            if (w_last_g) begin
              r_state <= ARB_IDLE;
              r_grant <= '0;
              r_rr    <= r_gidx;
            end
          end else if (!w_vld_g) begin
            if (w_to_hit) begin
              r_state <= ARB_IDLE;
              r_grant <= '0;
              r_rr    <= r_gidx;
              r_cnt   <= '0;
              r_tevt  <= 1'b1;
            end else if (r_cnt != '1) begin
              r_cnt <= r_cnt + TO_WIDTH'(1);
            end
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues drive the DUT,
// expected bytes are queued at send time and matched against observed FIFO writes.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            arb_en_i = 1'b1;
  logic [TW-1:0]   timeout_i = '0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N*8-1:0]  req_data_i = '0;
  logic [N-1:0]    req_last_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            tx_fifo_full_i = 1'b0;
  logic            tx_fifo_write_o;
  logic [7:0]      tx_data_o;
  logic [N-1:0]    grant_o;
  logic            busy_o;
  logic            timeout_evt_o;

  uart_tx_arbiter #(.NUM_REQ(N), .TO_WIDTH(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .arb_en_i       (arb_en_i),
    .timeout_i      (timeout_i),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_last_i     (req_last_i),
    .req_ready_o    (req_ready_o),
    .tx_fifo_full_i (tx_fifo_full_i),
    .tx_fifo_write_o(tx_fifo_write_o),
    .tx_data_o      (tx_data_o),
    .grant_o        (grant_o),
    .busy_o         (busy_o),
    .timeout_evt_o  (timeout_evt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus side: pending bytes per requester, and bytes expected on the FIFO port.
  logic [7:0] drv_dat_q [N][$];
  logic       drv_lst_q [N][$];
  logic [7:0] exp_q     [N][$];

  // Observation logs, written only by the monitor.
  int         obs_id_q[$];
  logic [7:0] obs_dat_q[$];
  int         obs_cyc_q[$];
  int         gnt_id_q[$];
  int         gnt_cyc_q[$];
  int         tevt_cyc_q[$];
  int         n_bad = 0;
  logic [N-1:0] hs_q = '0;
  logic [N-1:0] prev_grant = '0;

  int n_vec = 0;
  int n_err = 0;
  int obs_rd = 0;

  // Sample away from the active edge and log writes, grant rises, timeout pulses and protocol violations.
  always @(negedge clk) begin
    int id;
    hs_q = req_valid_i & req_ready_o;
    id = 99;
    if ($countones(grant_o) == 1) begin
      for (int k = 0; k < N; k++) if (grant_o[k]) id = k;
    end
    if (tx_fifo_write_o) begin
      obs_id_q.push_back(id);
      obs_dat_q.push_back(tx_data_o);
      obs_cyc_q.push_back(cyc);
    end
    if (grant_o != '0 && grant_o != prev_grant) begin
      gnt_id_q.push_back(id);
      gnt_cyc_q.push_back(cyc);
    end
    prev_grant = grant_o;
    if (timeout_evt_o) tevt_cyc_q.push_back(cyc);
    if ((tx_fifo_write_o && tx_fifo_full_i) ||
        (req_ready_o != '0 && tx_fifo_full_i) ||
        ((req_ready_o & ~grant_o) != '0)) n_bad++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int at_or(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      req_valid_i[k]        = (drv_dat_q[k].size() > 0);
      req_data_i[8*k +: 8]  = (drv_dat_q[k].size() > 0) ? drv_dat_q[k][0] : 8'h00;
      req_last_i[k]         = (drv_lst_q[k].size() > 0) ? drv_lst_q[k][0] : 1'b0;
    end
  endtask

  // Advance one cycle; retire bytes the DUT accepted in the previous cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs_q[k] && drv_dat_q[k].size() > 0) begin
        void'(drv_dat_q[k].pop_front());
        void'(drv_lst_q[k].pop_front());
      end
    end
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic last, input logic expect_wr);
    drv_dat_q[k].push_back(d);
    drv_lst_q[k].push_back(last);
    if (expect_wr) exp_q[k].push_back(d);
    refresh();
  endtask

  // Match every newly observed write against the expected queue of the granted requester.
  task automatic drain(input string tag);
    bit ok;
    while (obs_rd < obs_dat_q.size()) begin
      int id;
      id = obs_id_q[obs_rd];
      ok = (id < N) && (exp_q[id].size() > 0);
      check({tag, "_wr_expected"}, 32'(ok), 32'd1);
      if (ok) check({tag, "_wr_dat"}, 32'(obs_dat_q[obs_rd]), 32'(exp_q[id].pop_front()));
      obs_rd++;
    end
    for (int k = 0; k < N; k++) check({tag, "_exp_left"}, 32'(exp_q[k].size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_grant"}, 32'(grant_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
    check({tag, "_tevt"},  32'(timeout_evt_o), 32'd0);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd0);
    check({tag, "_write"}, 32'(tx_fifo_write_o), 32'd0);
    check({tag, "_data"},  32'(tx_data_o), 32'd0);
  endtask

  // Hold reset for two edges with all requesters flushed, then release.
  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      drv_dat_q[k].delete();
      drv_lst_q[k].delete();
    end
    refresh();
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    int c0, wb, gb, tb;

    // Reset state
    refresh();
    #1;
    check_outputs_zero("rst");
    do_reset();

    // Single 3-byte packet from requester 0
    c0 = cyc; wb = obs_cyc_q.size(); gb = gnt_cyc_q.size();
    send(0, 8'hA1, 1'b0, 1'b1);
    send(0, 8'hA2, 1'b0, 1'b1);
    send(0, 8'hA3, 1'b1, 1'b1);
    run(6);
    check("t1_gnt_id",  32'(at_or(gnt_id_q, gb)),  32'd0);
    check("t1_gnt_cyc", 32'(at_or(gnt_cyc_q, gb)), 32'(c0 + 1));
    check("t1_nwr", 32'(obs_cyc_q.size() - wb), 32'd3);
    for (int i = 0; i < 3; i++) check("t1_wr_cyc", 32'(at_or(obs_cyc_q, wb + i)), 32'(c0 + 1 + i));
    check("t1_idle_grant", 32'(grant_o), 32'd0);
    check("t1_idle_busy",  32'(busy_o), 32'd0);
    drain("t1");

    // All three requesters busy with 1-byte packets: rotation 0,1,2,0,1
    do_reset();
    c0 = cyc; wb = obs_cyc_q.size(); gb = gnt_cyc_q.size();
    send(0, 8'h10, 1'b1, 1'b1); send(0, 8'h11, 1'b1, 1'b1);
    send(1, 8'h20, 1'b1, 1'b1); send(1, 8'h21, 1'b1, 1'b1);
    send(2, 8'h30, 1'b1, 1'b1);
    run(12);
    for (int i = 0; i < 5; i++) begin
      check("t2_gnt_id", 32'(at_or(gnt_id_q, gb + i)), 32'((i == 0 || i == 3) ? 0 : (i == 1 || i == 4) ? 1 : 2));
      check("t2_wr_cyc", 32'(at_or(obs_cyc_q, wb + i)), 32'(c0 + 1 + 2*i));
    end
    drain("t2");

    // Requester 1 stalled by a full FIFO for 10 cycles; timeout must not fire
    timeout_i = 16'd4;
    c0 = cyc; wb = obs_cyc_q.size(); tb = tevt_cyc_q.size();
    send(1, 8'hB0, 1'b0, 1'b1); send(1, 8'hB1, 1'b0, 1'b1);
    send(1, 8'hB2, 1'b0, 1'b1); send(1, 8'hB3, 1'b1, 1'b1);
    run(3);
    tx_fifo_full_i = 1'b1;
    #1;
    check("t3_full_ready", 32'(req_ready_o), 32'd0);
    check("t3_full_write", 32'(tx_fifo_write_o), 32'd0);
    check("t3_full_busy",  32'(busy_o), 32'd1);
    run(9);
    check("t3_full_grant", 32'(grant_o), 32'b010);
    tick();
    tx_fifo_full_i = 1'b0;
    run(4);
    check("t3_nwr", 32'(obs_cyc_q.size() - wb), 32'd4);
    check("t3_wr2_cyc", 32'(at_or(obs_cyc_q, wb + 2)), 32'(c0 + 13));
    check("t3_wr3_cyc", 32'(at_or(obs_cyc_q, wb + 3)), 32'(c0 + 14));
    check("t3_no_tevt", 32'(tevt_cyc_q.size() - tb), 32'd0);
    drain("t3");

    // Requester 2 stalls after one non-last byte; limit 5, then requester 0 is next
    timeout_i = 16'd5;
    c0 = cyc; wb = obs_cyc_q.size(); gb = gnt_cyc_q.size(); tb = tevt_cyc_q.size();
    send(2, 8'hC0, 1'b0, 1'b1);
    run(3);
    send(0, 8'hD0, 1'b1, 1'b1);
    run(4);
    check("t4_revoked_grant", 32'(grant_o), 32'd0);
    check("t4_tevt_now", 32'(timeout_evt_o), 32'd1);
    run(3);
    check("t4_ntevt",   32'(tevt_cyc_q.size() - tb), 32'd1);
    check("t4_tevt_cyc", 32'(at_or(tevt_cyc_q, tb)), 32'(c0 + 7));
    check("t4_gnt0_id",  32'(at_or(gnt_id_q, gb)), 32'd2);
    check("t4_gnt1_id",  32'(at_or(gnt_id_q, gb + 1)), 32'd0);
    check("t4_gnt1_cyc", 32'(at_or(gnt_cyc_q, gb + 1)), 32'(c0 + 8));
    check("t4_d0_cyc",   32'(at_or(obs_cyc_q, wb + 1)), 32'(c0 + 8));
    drain("t4");

    // arb_en_i dropped mid-packet: packet finishes, requester 1 waits for re-enable
    timeout_i = '0;
    c0 = cyc; wb = obs_cyc_q.size(); gb = gnt_cyc_q.size();
    send(0, 8'hE0, 1'b0, 1'b1); send(0, 8'hE1, 1'b0, 1'b1);
    send(0, 8'hE2, 1'b0, 1'b1); send(0, 8'hE3, 1'b1, 1'b1);
    run(2);
    arb_en_i = 1'b0;
    send(1, 8'hF0, 1'b1, 1'b1);
    run(8);
    check("t5_disabled_grant", 32'(grant_o), 32'd0);
    arb_en_i = 1'b1;
    run(3);
    check("t5_e3_cyc", 32'(at_or(obs_cyc_q, wb + 3)), 32'(c0 + 4));
    check("t5_gnt1_id",  32'(at_or(gnt_id_q, gb + 1)), 32'd1);
    check("t5_gnt1_cyc", 32'(at_or(gnt_cyc_q, gb + 1)), 32'(c0 + 11));
    drain("t5");

    // Reset mid-packet from requester 2, then requester 0 beats requester 2
    send(2, 8'h60, 1'b0, 1'b1); send(2, 8'h61, 1'b0, 1'b1);
    send(2, 8'h62, 1'b0, 1'b0); send(2, 8'h63, 1'b1, 1'b0);
    run(3);
    rst = 1'b1;
    #1;
    check_outputs_zero("t6_async");
    do_reset();
    c0 = cyc; gb = gnt_cyc_q.size();
    send(2, 8'h70, 1'b1, 1'b1);
    send(0, 8'h71, 1'b1, 1'b1);
    run(6);
    check("t6_gnt0_id",  32'(at_or(gnt_id_q, gb)), 32'd0);
    check("t6_gnt0_cyc", 32'(at_or(gnt_cyc_q, gb)), 32'(c0 + 1));
    check("t6_gnt1_id",  32'(at_or(gnt_id_q, gb + 1)), 32'd2);
    drain("t6");

    check("protocol_violations", 32'(n_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
